// File: rtl/mem_burst_master_if.sv
// Valid/ready access bus between a burst initiator and a single-port memory.
// The initiator drives the request fields; the memory answers with ready and read data.
interface mem_burst_master_if #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr_rd;
    logic [WIDTH-1:0]      w_data;
    logic                  valid;
    logic                  ready;
    logic [WIDTH-1:0]      r_data;

    modport master (output addr, wr_rd, w_data, valid, input ready, r_data);
    modport slave  (input addr, wr_rd, w_data, valid, output ready, r_data);
endinterface

// File: rtl/mem_burst_master.sv
// Burst initiator: runs one valid/ready memory transaction per beat and returns read data.
// Optional read-compare error counter enabled by defining MEM_BURST_MASTER_CHECK_EN.
module mem_burst_master #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode_wr,
    input  logic                  dir,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   count,
    input  logic [WIDTH-1:0]      seed,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_vld,
    output logic [ADDR_WIDTH:0]   rd_idx,
    output logic [ADDR_WIDTH:0]   err_cnt,
    mem_burst_master_if.master    mem
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    localparam logic [ADDR_WIDTH:0]   DEPTH_C   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   ONE_C     = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_A     = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                state;
    logic                  mode_q;
    logic                  dir_q;
    logic [WIDTH-1:0]      seed_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   beat;
    logic [ADDR_WIDTH:0]   beat_nxt;
    logic [ADDR_WIDTH:0]   len_in;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic                  hs;

    assign hs       = (state == XFER) && mem.valid && mem.ready;
    assign beat_nxt = beat + ONE_C;
    assign len_in   = (count > DEPTH_C) ? DEPTH_C : count;

    // Explicit wrap works for any DEPTH, not only powers of two.
    // NOTE: default assignment first so every path assigns addr_nxt and no latch is inferred.
    always_comb begin
        addr_nxt = mem.addr;
        if (dir_q)
            addr_nxt = (mem.addr == '0) ? LAST_ADDR : mem.addr - ONE_A;
        else
            addr_nxt = (mem.addr == LAST_ADDR) ? '0 : mem.addr + ONE_A;
    end

    // NOTE: sequential state uses non-blocking assignments; async reset clears every output flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mode_q     <= 1'b0;
            dir_q      <= 1'b0;
            seed_q     <= '0;
            len_q      <= '0;
            beat       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_data    <= '0;
            rd_vld     <= 1'b0;
            rd_idx     <= '0;
            mem.addr   <= '0;
            mem.wr_rd  <= 1'b0;
            mem.w_data <= '0;
            mem.valid  <= 1'b0;
        end else begin
            done   <= 1'b0;
            rd_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q <= mode_wr;
                        dir_q  <= dir;
                        seed_q <= seed;
                        len_q  <= len_in;
                        beat   <= '0;
                        busy   <= 1'b1;
                        if (len_in != '0) begin
                            state      <= XFER;
                            mem.valid  <= 1'b1;
                            mem.wr_rd  <= mode_wr;
                            mem.addr   <= start_addr;
                            mem.w_data <= mode_wr ? seed : '0;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                XFER: begin
                    if (hs) begin
                        if (!mode_q) begin
                            rd_data <= mem.r_data;
                            rd_idx  <= beat;
                            rd_vld  <= 1'b1;
                        end
                        beat <= beat_nxt;
                        if (beat_nxt == len_q) begin
                            state      <= DONE;
                            done       <= 1'b1;
                            mem.valid  <= 1'b0;
                            mem.wr_rd  <= 1'b0;
                            mem.addr   <= '0;
                            mem.w_data <= '0;
                        end else begin
                            mem.addr <= addr_nxt;
                            if (mode_q)
                                mem.w_data <= seed_q + WIDTH'(beat_nxt);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_BURST_MASTER_CHECK_EN
    logic [WIDTH-1:0] expect_rd;
    assign expect_rd = seed_q + WIDTH'(beat);

    // Cleared by each accepted command, saturating on read-compare mismatches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt <= '0;
        else if (state == IDLE && start)
            err_cnt <= '0;
        else if (hs && !mode_q && mem.r_data != expect_rd && err_cnt != '1)
            err_cnt <= err_cnt + ONE_C;
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: doc/mem_burst_master.md
# mem_burst_master

Initiator for the single-port memory's valid/ready access interface. It accepts a burst command (direction, start address, beat count, data seed), sequences one memory transaction per beat over the handshake, generates write data, and returns captured read data to the host. In bring-up and self-test it replaces ad-hoc driver code, sitting between a controller/sequencer and the memory block.

## Interface
- WIDTH, 8, data width in bits
- DEPTH, 16, memory depth in words
- ADDR_WIDTH, $clog2(DEPTH), address width

Host side:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  command strobe; sampled only in IDLE
- mode_wr  input  1  1 = write burst, 0 = read burst
- dir  input  1  0 = ascending addresses, 1 = descending addresses
- start_addr  input  ADDR_WIDTH  first beat address
- count  input  ADDR_WIDTH+1  number of beats; 0 is legal
- seed  input  WIDTH  data pattern base
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse at burst end
- rd_data  output  WIDTH  captured read word
- rd_vld  output  1  one-cycle pulse per captured read beat
- rd_idx  output  ADDR_WIDTH+1  beat index of rd_data
- err_cnt  output  ADDR_WIDTH+1  read-compare mismatch count

Memory side:
- addr  output  ADDR_WIDTH  transaction address
- wr_rd  output  1  1 = write, 0 = read
- w_data  output  WIDTH  write data
- valid  output  1  transaction request
- ready  input  1  responder acceptance
- r_data  input  WIDTH  read data, valid when ready is high on a read

## Operation
- States: IDLE, XFER, DONE.
- IDLE: all memory-side outputs 0. start=1 latches mode_wr, dir, start_addr, seed, and count. count > DEPTH is clamped to DEPTH. Goes to XFER if count != 0, otherwise to DONE.
- XFER: valid=1, wr_rd=latched mode, addr=current address, w_data=seed+beat (mod 2^WIDTH, write mode only; 0 in read mode).
  - Beat completes on a rising edge where valid && ready.
  - On a completing beat: beat++, and the address steps +1 (dir=0) or -1 (dir=1), modulo DEPTH. A power-of-2 DEPTH wraps naturally; other depths wrap explicitly (DEPTH-1 -> 0, 0 -> DEPTH-1).
  - After the last beat: go to DONE.
- DONE: done=1, valid=0 for one cycle, then IDLE.
- Read capture: on a completing read beat, rd_data<=r_data, rd_idx<=beat, and rd_vld pulses the following cycle.
- start while busy is ignored. Command inputs are sampled only in IDLE.
- Outputs are held stable while valid=1 and ready=0. valid is never withdrawn before the handshake completes.

## Timing
- Reset values: state IDLE; busy, done, valid, wr_rd, rd_vld = 0; addr, w_data, rd_data, rd_idx, err_cnt = 0.
- Reset takes effect immediately, including mid-burst. valid drops asynchronously, and the burst is abandoned with no done pulse.
- start sampled at edge E0. valid=1 with the first address after E0. With ready tied high, beats complete at E1..EN, done is high between EN and EN+1, and busy falls after EN+1.
- Back-to-back beats: valid stays high, and addr/w_data update in the cycle after each handshake, giving 1 beat/cycle throughput.
- count=0: done pulses in the cycle after E0 and no valid is issued.
- err_cnt clears on each accepted start and saturates at all-ones.

## Configuration
- MEM_BURST_MASTER_CHECK_EN:
  - Defined: in read mode, each captured r_data is compared against seed+beat, and err_cnt increments on each mismatch.
  - Undefined: the compare logic is absent and err_cnt is tied to 0.
  - Port list is identical in both cases.

## Test plan
- Write ascending, start_addr=0, count=16, seed=8'h10, ready=1 -> addr 0..15, w_data 8'h10..8'h1F, 16 valid cycles, done one cycle after the 16th handshake.
- Read descending, start_addr=3, count=5, memory preloaded with 8'hA0+addr -> addr 3,2,1,0,15; rd_data A3,A2,A1,A0,AF with rd_idx 0..4.
- Write with ready held low 3 cycles on beat 2 (start_addr=4, count=4, seed=8'h00) -> addr=6 and w_data=8'h02 held stable with valid=1 until accepted; done 3 cycles later than the no-stall case.
- count=0, then count=20 -> first: no valid, done next cycle; second: clamped to 16 beats.
- Assert rst after beat 4 of a 16-beat write -> valid, busy = 0 immediately and no done pulse; a new start after reset runs a full burst correctly.
- Write count=8, seed=8'h30, then read back with memory corrupting addr 5 -> err_cnt=1 with MEM_BURST_MASTER_CHECK_EN, 0 without.
